// File: rtl/rs544_encoder_lal32.sv
`timescale 1ns/1ps
// rs544_encoder_lal32
// Systematic RS(544,522) encoder over GF(2^10) (x^10+x^3+1), 32 symbols per frame.
// Message frames pass straight through. The 22 parity symbols, the remainder of the
// message polynomial modulo g(x)=prod_{j=1..22}(x+a^j), replace the low half of frame 16.
module rs544_encoder_lal32 (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             start_i,
    input  logic             last_i,
    input  logic [31:0][9:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic             start_o,
    output logic             last_o,
    output logic [31:0][9:0] data_o,
    input  logic             ready_i,
    output logic             err_o
);

    localparam int J          = 22;     // parity symbols / generator degree
    localparam int M          = 32;     // symbols per frame
    localparam int SW         = 10;     // symbol width
    localparam int TAIL_STEPS = 10;     // message symbols [31:22] carried by frame 16
    localparam logic [4:0] LAST_CNT = 5'd16;

    // Multiply by alpha: shift up and fold x^10 back as x^3+1.
    function automatic logic [SW-1:0] gf_xtime(input logic [SW-1:0] a);
        return {a[SW-2:0], 1'b0} ^ (a[SW-1] ? 10'h009 : 10'h000);
    endfunction

    // General product, only ever evaluated on constants while building the tables below.
    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] acc;
        logic [SW-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < SW; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Generator coefficients g[0..22], built by multiplying in (x + a^j) for j=1..22.
    function automatic logic [J:0][SW-1:0] gen_poly();
        logic [J:0][SW-1:0] g;
        logic [SW-1:0]      root;
        g    = '0;
        g[0] = 10'h001;
        root = 10'h001;
        for (int j = 1; j <= J; j++) begin
            root = gf_xtime(root);
            for (int i = J; i >= 1; i--) begin
                g[i] = g[i-1] ^ gf_mul(g[i], root);
            end
            g[0] = gf_mul(g[0], root);
        end
        return g;
    endfunction

    // Constant-multiplier matrices: column i of entry j is g[j]*a^i, so a product
    // with g[j] is the XOR of the columns selected by the bits of the operand.
    function automatic logic [J-1:0][SW-1:0][SW-1:0] build_gmat();
        logic [J:0][SW-1:0]          g;
        logic [J-1:0][SW-1:0][SW-1:0] mat;
        logic [SW-1:0]               col;
        g   = gen_poly();
        mat = '0;
        for (int j = 0; j < J; j++) begin
            col = g[j];
            for (int i = 0; i < SW; i++) begin
                mat[j][i] = col;
                col       = gf_xtime(col);
            end
        end
        return mat;
    endfunction

    localparam logic [J-1:0][SW-1:0][SW-1:0] GMAT = build_gmat();

    // XOR tree for one constant multiplier.
    function automatic logic [SW-1:0] cmul(input logic [SW-1:0] a, input logic [SW-1:0][SW-1:0] mat);
        logic [SW-1:0] p;
        p = '0;
        for (int i = 0; i < SW; i++) begin
            p = p ^ ({SW{a[i]}} & mat[i]);
        end
        return p;
    endfunction

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [J-1:0][SW-1:0]   r_q, r_d;
    logic                   valid_q, valid_d;
    logic                   start_q, start_d;
    logic                   last_q, last_d;
    logic [M-1:0][SW-1:0]   data_q, data_d;
    logic                   err_q, err_d;

    logic [J-1:0][SW-1:0]   r_work;
    logic [J-1:0][SW-1:0]   r_tail;
    logic [J-1:0][SW-1:0]   r_full;
    logic [SW-1:0]          fb;
    logic                   accept;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    // Symbol-serial division unrolled over the frame, highest symbol first; the tap after
    // ten steps is the final-frame parity, the full chain is the regular remainder update.
    always_comb begin
        r_work = start_i ? '0 : r_q;
        r_tail = '0;
        fb     = '0;
        for (int s = 0; s < M; s++) begin
            fb = r_work[J-1] ^ data_i[M-1-s];
            for (int j = J-1; j >= 1; j--) begin
                r_work[j] = r_work[j-1] ^ cmul(fb, GMAT[j]);
            end
            r_work[0] = cmul(fb, GMAT[0]);
            if (s == TAIL_STEPS-1) r_tail = r_work;
        end
        r_full = r_work;
    end

    // Frame sequencing, protocol-error detection and output register loading.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        valid_d = valid_q;
        start_d = start_q;
        last_d  = last_q;
        data_d  = data_q;
        err_d   = 1'b0;

        if (valid_q && ready_i) valid_d = 1'b0;

        if (accept) begin
            if (start_i) begin
                err_d   = (state_q == ST_BUSY) || last_i;
                valid_d = 1'b1;
                start_d = 1'b1;
                data_d  = data_i;
                if (last_i) begin
                    last_d  = 1'b1;
                    r_d     = '0;
                    cnt_d   = 5'd0;
                    state_d = ST_IDLE;
                end else begin
                    last_d  = 1'b0;
                    r_d     = r_full;
                    cnt_d   = 5'd1;
                    state_d = ST_BUSY;
                end
            end else if (state_q == ST_IDLE) begin
                err_d = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
                err_d   = !last_i;
                valid_d = 1'b1;
                start_d = 1'b0;
                last_d  = 1'b1;
                data_d  = {data_i[M-1:J], r_tail};
                r_d     = '0;
                cnt_d   = 5'd0;
                state_d = ST_IDLE;
            end else if (last_i) begin
                err_d   = 1'b1;
                valid_d = 1'b1;
                start_d = 1'b0;
                last_d  = 1'b1;
                data_d  = data_i;
                r_d     = '0;
                cnt_d   = 5'd0;
                state_d = ST_IDLE;
            end else begin
                valid_d = 1'b1;
                start_d = 1'b0;
                last_d  = 1'b0;
                data_d  = data_i;
                r_d     = r_full;
                cnt_d   = cnt_q + 5'd1;
            end
        end
    end

    // State, remainder and output registers; reset discards any partial codeword.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            r_q     <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            start_q <= start_d;
            last_q  <= last_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign start_o = start_q;
    assign last_o  = last_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_rs544_encoder_lal32.sv
`timescale 1ns/1ps
// tb_rs544_encoder_lal32
// Codewords are built as whole 544-symbol arrays; parity comes from polynomial long
// division by g(x). Expected frames go into a queue, a monitor pops them on each output
// handshake, and every complete output codeword is also checked for zero syndromes.
module tb_rs544_encoder_lal32;

    typedef struct packed {
        logic [31:0][9:0] data;
        logic             start;
        logic             last;
    } frame_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             start_i;
    logic             last_i;
    logic [31:0][9:0] data_i;
    logic             ready_o;
    logic             valid_o;
    logic             start_o;
    logic             last_o;
    logic [31:0][9:0] data_o;
    logic             ready_i;
    logic             err_o;

    frame_t     exp_q[$];
    int         total, bad;
    int         exp_err, err_seen;
    int         hs_count, first_hs, last_hs, cyc;
    int         stall_run;
    bit         stall_en;
    bit         tb_busy;
    logic [9:0] cw [544];
    logic [9:0] rx [544];
    int         rx_idx;
    logic [9:0] gen [23];

    rs544_encoder_lal32 dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .start_i (start_i),
        .last_i  (last_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .start_o (start_o),
        .last_o  (last_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    function automatic logic [9:0] gfMul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] acc;
        logic [9:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[8:0], 1'b0} ^ (sh[9] ? 10'h009 : 10'h000);
        end
        return acc;
    endfunction

    function automatic logic [9:0] alphaPow(input int e);
        logic [9:0] v;
        v = 10'h001;
        for (int i = 0; i < e; i++) v = gfMul(v, 10'h002);
        return v;
    endfunction

    task automatic buildGenerator();
        logic [9:0] g [23];
        logic [9:0] root;
        for (int i = 0; i < 23; i++) g[i] = '0;
        g[0] = 10'h001;
        for (int j = 1; j <= 22; j++) begin
            root = alphaPow(j);
            for (int i = 22; i >= 1; i--) g[i] = g[i-1] ^ gfMul(g[i], root);
            g[0] = gfMul(g[0], root);
        end
        for (int i = 0; i < 23; i++) gen[i] = g[i];
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
        end
    endtask

    // Message symbols cw[543..22]; kind 0 all zero, 1 single leading 0x001, 2 random.
    task automatic genMessage(input int kind);
        for (int i = 0; i < 544; i++) cw[i] = '0;
        if (kind == 1) cw[543] = 10'h001;
        if (kind == 2) for (int i = 22; i < 544; i++) cw[i] = 10'($urandom_range(0, 1023));
    endtask

    // Parity = message polynomial (with zeros in the parity slots) mod g(x), by long division.
    task automatic computeParity();
        logic [9:0] rem [544];
        logic [9:0] coef;
        for (int i = 0; i < 544; i++) rem[i] = (i >= 22) ? cw[i] : 10'h000;
        for (int i = 543; i >= 22; i--) begin
            coef = rem[i];
            if (coef != 10'h000)
                for (int j = 0; j <= 22; j++) rem[i-22+j] = rem[i-22+j] ^ gfMul(coef, gen[j]);
        end
        for (int i = 0; i < 22; i++) cw[i] = rem[i];
    endtask

    function automatic logic [31:0][9:0] frameOf(input int k);
        logic [31:0][9:0] f;
        for (int m = 0; m < 32; m++) f[m] = cw[512 - 32*k + m];
        return f;
    endfunction

    // Drive one frame until accepted; push its expected output once accepted.
    task automatic applyStimulus(input logic [31:0][9:0] d, input logic s, input logic l,
                                 input bit emit, input logic [31:0][9:0] ed,
                                 input logic es, input logic el);
        bit acc;
        int waitc;
        frame_t f;
        valid_i = 1'b1;
        data_i  = d;
        start_i = s;
        last_i  = l;
        acc     = 1'b0;
        waitc   = 0;
        while (!acc) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            if (!acc) begin
                waitc++;
                if (waitc > 200) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL accept_timeout got=not_ready want=accept");
                    break;
                end
            end
        end
        if (acc && emit) begin
            f.data  = ed;
            f.start = es;
            f.last  = el;
            exp_q.push_back(f);
        end
        valid_i = 1'b0;
    endtask

    // Send frames 0..nframes-1 of a fresh codeword; early_last marks the last sent frame.
    task automatic sendCodeword(input int kind, input int nframes, input bit early_last,
                                input bit last_on_final);
        logic [31:0][9:0] d;
        logic [31:0][9:0] din;
        logic             l;
        logic             el;
        bit               fe;
        genMessage(kind);
        computeParity();
        for (int k = 0; k < nframes; k++) begin
            d   = frameOf(k);
            din = d;
            l   = 1'b0;
            el  = 1'b0;
            fe  = (k == 0) && tb_busy;
            if (k == 16) begin
                for (int m = 0; m < 22; m++) din[m] = 10'($urandom_range(0, 1023));
                l  = last_on_final;
                el = 1'b1;
                if (!last_on_final) fe = 1'b1;
            end else if (early_last && k == nframes-1) begin
                l  = 1'b1;
                el = 1'b1;
                fe = 1'b1;
            end
            if (fe) exp_err++;
            applyStimulus(din, (k == 0), l, 1'b1, d, (k == 0), el);
        end
        tb_busy = !(nframes == 17 || early_last);
    endtask

    task automatic finishScenario(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(posedge clk_i);
            w++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        checkValue({name, "_queue_left"}, exp_q.size(), 0);
        checkValue({name, "_err_pulses"}, err_seen, exp_err);
    endtask

    task automatic checkResetOutputs(input string name);
        checkValue({name, "_valid"}, int'(valid_o), 0);
        checkValue({name, "_start"}, int'(start_o), 0);
        checkValue({name, "_last"}, int'(last_o), 0);
        checkValue({name, "_err"}, int'(err_o), 0);
        total++;
        if (data_o !== '0) begin
            bad++;
            $display("[TB] FAIL %s_data got=%h want=0", name, data_o);
        end
    endtask

    task automatic checkOutput();
        frame_t got;
        frame_t want;
        got = {data_o, start_o, last_o};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_frame got start=%0b last=%0b data=%h want none",
                     start_o, last_o, data_o);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL frame got start=%0b last=%0b data=%h want start=%0b last=%0b data=%h",
                         got.start, got.last, got.data, want.start, want.last, want.data);
            end
        end
    endtask

    task automatic trackSyndrome();
        logic [9:0] s;
        logic [9:0] a;
        int         badj;
        if (start_o) rx_idx = 0;
        if (rx_idx < 17) for (int m = 0; m < 32; m++) rx[512 - 32*rx_idx + m] = data_o[m];
        rx_idx++;
        if (last_o && rx_idx == 17) begin
            badj = 0;
            for (int j = 1; j <= 22; j++) begin
                a = alphaPow(j);
                s = '0;
                for (int i = 543; i >= 0; i--) s = gfMul(s, a) ^ rx[i];
                if (s != 10'h000 && badj == 0) badj = j;
            end
            total++;
            if (badj != 0) begin
                bad++;
                $display("[TB] FAIL syndrome index=%0d got=nonzero want=000", badj);
            end
        end
    endtask

    // Output monitor: counts error pulses and checks every handshaked frame.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (err_o) err_seen++;
            if (valid_o && ready_i) begin
                hs_count++;
                if (hs_count == 1) first_hs = cyc;
                last_hs = cyc;
                checkOutput();
                trackSyndrome();
            end
        end
    end

    // Downstream ready: constantly high, or random with occasional 3-cycle stalls.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (!stall_en) ready_i = 1'b1;
            else if (stall_run > 0) begin
                ready_i = 1'b0;
                stall_run--;
            end else if ($urandom_range(0, 7) == 0) begin
                ready_i   = 1'b0;
                stall_run = 2;
            end else ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0][9:0] junk;
        total = 0; bad = 0; exp_err = 0; err_seen = 0;
        hs_count = 0; first_hs = 0; last_hs = 0; cyc = 0; rx_idx = 17;
        stall_run = 0; stall_en = 1'b0; tb_busy = 1'b0;
        rst_ni = 1'b0; valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0; data_i = '0;
        buildGenerator();

        repeat (2) @(negedge clk_i);
        checkResetOutputs("power_on_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        hs_count = 0;
        sendCodeword(0, 17, 1'b0, 1'b1);
        finishScenario("all_zero");
        checkValue("all_zero_frames", hs_count, 17);
        checkValue("all_zero_span", last_hs - first_hs, 16);

        sendCodeword(1, 17, 1'b0, 1'b1);
        finishScenario("single_symbol");

        hs_count = 0;
        for (int n = 0; n < 20; n++) sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("random_b2b");
        checkValue("random_b2b_frames", hs_count, 340);
        checkValue("random_b2b_span", last_hs - first_hs, 339);

        stall_en = 1'b1;
        for (int n = 0; n < 4; n++) sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("stalls");
        stall_en = 1'b0;

        junk = '0;
        for (int m = 0; m < 32; m++) junk[m] = 10'($urandom_range(1, 1023));
        exp_err++;
        applyStimulus(junk, 1'b0, 1'b0, 1'b0, junk, 1'b0, 1'b0);
        sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("no_start_drop");

        sendCodeword(2, 6, 1'b1, 1'b1);
        sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("early_last_cnt5");

        sendCodeword(2, 17, 1'b0, 1'b0);
        finishScenario("final_without_last");

        sendCodeword(2, 8, 1'b0, 1'b1);
        sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("abort_restart");

        sendCodeword(2, 1, 1'b1, 1'b1);
        sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("start_and_last");

        sendCodeword(2, 8, 1'b0, 1'b1);
        finishScenario("pre_reset");
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkResetOutputs("mid_codeword_reset");
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        tb_busy = 1'b0;
        sendCodeword(2, 17, 1'b0, 1'b1);
        finishScenario("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs544_encoder_lal32.md
# rs544_encoder_lal32

Systematic RS(544,522) encoder over GF(2^10), 32 symbols per cycle. It is the transmit-side counterpart of the decoder's syndrome stage. It accepts 522 message symbols as 17 input frames, passes message symbols through unchanged, and inserts 22 parity symbols into the low half of the 17th frame. Every codeword it emits must produce all-zero syndromes S_1..S_22 at the decoder.

## Interface
- J, 22, number of parity symbols; generator roots α^1..α^J
- M, 32, symbols per frame; 544/M = 17 frames per codeword
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input frame valid
- start_i  in  1  first frame of codeword (frame 0)
- last_i  in  1  final frame of codeword (frame 16)
- data_i  in  [M-1:0][9:0]  frame k: data_i[m] = codeword[543-32k-(31-m)]; frame 16: only [31:22] are meaningful, [21:0] are ignored
- ready_o  out  1  input accepted when valid_i && ready_o
- valid_o  out  1  output frame valid
- start_o  out  1  start flag, aligned with valid_o
- last_o  out  1  last flag, aligned with valid_o
- data_o  out  [M-1:0][9:0]  encoded frame; same symbol ordering as data_i
- ready_i  in  1  downstream ready
- err_o  out  1  one-cycle protocol-error pulse

## Operation
- Field: GF(2^10), primitive polynomial x^10+x^3+1, polynomial basis, α=0x002.
- Generator: g(x)=∏_{j=1..22}(x+α^j), degree 22.
- Remainder register: R[21:0] of 10-bit symbols, representing R(x).
- Frame k in 0..15: R ← (R(x)·x^32 + D(x)·x^22) mod g(x), where D(x)=Σ data_i[m]·x^m.
  - Data is forwarded unchanged.
- Frame 16:
  - Compute P(x) = (R(x)·x^10 + Σ_{m=22..31} data_i[m]·x^(m-22)·x^22) mod g(x).
  - data_o[31:22] = data_i[31:22]; data_o[i] = P_i for i in 0..21.
  - R is then cleared.
- Implement the updates with constant GF multipliers and XOR trees: an unrolled LFSR or precomputed matrices, designer's choice. No variable×variable multipliers.
- Frame counter cnt (0..16, 5 bits) and state machine:
  - IDLE: accepted frame with start_i=1 loads R from frame 0 with R_prev=0, cnt←1, go to BUSY. Accepted frame with start_i=0 is dropped and pulses err_o.
  - BUSY:
    - start_i=1: abort the current codeword, pulse err_o, and treat the frame as a new frame 0. No parity is emitted for the aborted codeword.
    - cnt<16 and last_i=1: pulse err_o, forward the frame unmodified with last_o=1, clear R, go to IDLE.
    - cnt==16: encode as the final frame whatever last_i is. If last_i=0, pulse err_o. last_o is forced to 1. Go to IDLE.
  - A frame with start_i=1 and last_i=1 in IDLE is a frame-0 start with an early last: apply the BUSY early-last rule.
- start_o and last_o mirror the accepted flags, except that last_o is forced on frame 16.

## Timing
- Single output register stage. Latency is 1 cycle from accept to valid_o.
- ready_o = !valid_o || ready_i (combinational).
- Output register loads on accept. valid_o clears when valid_o && ready_i && no accept.
- While valid_o && !ready_i: data_o, start_o, last_o, valid_o are held stable, and ready_o=0.
- Throughput is 1 frame/cycle with ready_i=1. Back-to-back codewords need no bubble: frame 0 of the next codeword may follow frame 16 directly.
- err_o is registered: it pulses the cycle after the offending accept, independent of ready_i.
- Reset (asynchronous, any time, including mid-codeword): valid_o=0, start_o=0, last_o=0, data_o=0, err_o=0, R=0, cnt=0, state IDLE. Any partial codeword is discarded.

## Test plan
- All-zero message, 17 frames, ready_i=1 → data_o all zero including parity; valid_o on cycles 1..17; last_o only on the 17th output; err_o=0.
- Single nonzero message symbol (codeword[543]=0x001) plus 20 random messages → feed outputs into syndrome_lal32; every syndrome is 0x000; parity matches the software model bit-exactly.
- Random message with ready_i toggled pseudo-randomly (including 3-cycle stalls mid-codeword and on frame 16) → output sequence identical to the no-stall run; no frame lost or duplicated.
- Two codewords back-to-back, second starting the cycle after frame 16 is accepted → both parity sets correct; no idle cycle on valid_o.
- Protocol errors:
  - Frame without start in IDLE → dropped, err_o one cycle.
  - last_i at cnt=5 → forwarded with last_o=1, err_o, and the next start encodes correctly.
  - Frame 16 with last_i=0 → parity still inserted, last_o=1, err_o.
- rst_ni asserted at frame 8, released, then a full codeword sent → outputs at reset values during reset; the subsequent codeword encodes correctly with no residue in R.
